lidar_cmd_rx: RTL and testbench
===============================

# lidar_cmd_rx

Host-to-device command receiver for the lidar frame-view design: the receive-direction counterpart of the serial frame transmitter. It deserialises 8N1 UART bytes from `rs232_rx`, parses fixed-length checksummed command frames, and holds the runtime configuration registers. Those registers are `time_set`, `resolution`, `enable` and `serialsend_flag`. At top level they replace the constant assignments feeding the sampling-control and serial-send blocks.

## Interface
Parameters:
- `BAUD_DIV`, default 434: clocks per bit (50 MHz / 115200).
- `TIMEOUT_CYC`, default 50000: inter-byte timeout in clocks (1 ms). Used only with `CMD_RX_TIMEOUT_EN`.

Ports:
- `clk` input 1: module clock, 50 MHz. Single clock domain.
- `rst_n` input 1: reset, synchronous, active-low.
- `rs232_rx` input 1: UART RX line, asynchronous, idle high.
- `time_set` output 26: sampling time setting. Reset value 22000.
- `resolution` output 9: angular resolution. Reset value 10. Legal range 1..360.
- `enable` output 1: sampling enable. Reset value 1.
- `serialsend_flag` output 1: send-protocol flag. Reset value 1.
- `cmd_strobe` output 1: one-cycle pulse when a valid command is applied. Reset value 0.
- `cmd_code` output 8: code of the last applied command. Reset value 0x00.
- `cmd_err` output 1: one-cycle pulse on a rejected frame or framing error. Reset value 0.

## Operation
- **Input sync:** `rs232_rx` passes through two flip-flops; all logic uses the synchronised copy.
- **Receiver FSM:** states RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE → RX_START on a synchronised falling edge.
  - RX_START: wait BAUD_DIV/2 clocks, then resample. If the line is high, it is a glitch: return to RX_IDLE with no error.
  - RX_DATA: sample 8 bits, LSB first, every BAUD_DIV clocks.
  - RX_STOP: sample once at mid-bit. If 1, pulse internal `byte_vld` on the next cycle. If 0, raise a framing error: discard the byte, pulse `cmd_err`, return the parser to P_HDR.
- **After reset:** the receiver does not arm until it has seen the line high for at least one clock. A line held low through reset is not a start bit.
- **Frame format:** 7 bytes: `0xA5`, CMD, D3, D2, D1, D0, SUM.
  - Payload is 32-bit big-endian.
  - SUM = (CMD + D3 + D2 + D1 + D0) mod 256.
- **Parser FSM:** states P_HDR → P_CMD → P_D3 → P_D2 → P_D1 → P_D0 → P_SUM, advancing one state per `byte_vld`.
  - In P_HDR, any byte other than 0xA5 is ignored silently.
  - After P_SUM, the parser always returns to P_HDR.
- **Command decode** (evaluated on the SUM byte):
  - 0x01: `time_set` ← payload[25:0]. Error if payload[31:26] ≠ 0.
  - 0x02: `resolution` ← payload[8:0]. Error if payload is 0 or greater than 360.
  - 0x03: `enable` ← payload[0], `serialsend_flag` ← payload[1]. Other payload bits are ignored.
  - Any other code is an error.
- **Error handling:** a checksum mismatch, range violation or unknown code pulses `cmd_err`. Registers and `cmd_code` are unchanged.
- **Atomicity:** each command updates only its own registers. There are no partial updates.

## Timing
- Stop-bit mid-sample at cycle N. `byte_vld` is high at N+1. For a SUM byte, registers, `cmd_code` and `cmd_strobe` update at N+2.
- `cmd_strobe` and `cmd_err` are each exactly one cycle wide and never both high in the same cycle.
- Back-to-back frames with zero idle time between stop and start bits are accepted.
- A new start edge can be detected in the cycle after the stop-bit sample.
- `rst_n` low mid-frame or mid-byte, at the next clock edge:
  - all outputs return to their reset values;
  - receiver goes to RX_IDLE and parser to P_HDR;
  - the partial frame is lost and no `cmd_err` is raised.
- Counter widths: bit counter 4 bits; baud counter ⌈log2(BAUD_DIV)⌉ bits; checksum accumulator 8 bits, wrapping.

## Configuration
- Macro `CMD_RX_TIMEOUT_EN`.
- **Defined:** a counter starts whenever the parser is outside P_HDR and the receiver is in RX_IDLE. It clears on every `byte_vld`. On reaching TIMEOUT_CYC, the parser returns to P_HDR and `cmd_err` pulses once.
- **Undefined:** no timeout logic. The parser waits indefinitely for the remaining bytes of a frame.

## Test plan
- Send A5 01 00 00 27 10 38 → `time_set` = 10000, `cmd_strobe` pulse, `cmd_code` = 0x01, 2 clocks after the last stop-bit sample.
- Send A5 02 00 00 01 68 6B → `resolution` = 360. Then send A5 02 00 00 01 69 6C (value 361) → `cmd_err` pulse, `resolution` stays 360.
- Send A5 03 00 00 00 00 03 → `enable` = 0, `serialsend_flag` = 0. Then send the same frame with SUM = 0x04 → `cmd_err`, no change.
- Send 0x55 0x00 then a valid frame, followed back-to-back by a byte with stop bit forced 0 → the garbage bytes are ignored, the valid frame is applied, and the bad byte causes exactly one `cmd_err`.
- Assert `rst_n` low after A5 01 00, then release and send a valid frame → registers are at defaults (22000/10/1/1) after reset, and only the new frame is applied.
- With `CMD_RX_TIMEOUT_EN`: send A5 01, idle 50000+ clocks → one `cmd_err`, parser back to P_HDR. A following valid frame is applied.

Source files
------------

// File: rtl/lidar_cmd_rx.sv
// lidar_cmd_rx: 8N1 UART command receiver that holds the lidar runtime configuration registers.
// Define CMD_RX_TIMEOUT_EN to build the inter-byte timeout that abandons stalled frames.
//
// state      | meaning
// RX_IDLE    | line idle, waiting for a synchronised falling edge
// RX_START   | half-bit wait, then confirm the start bit
// RX_DATA    | sampling 8 data bits, LSB first
// RX_STOP    | sampling the stop bit at mid-bit
// P_HDR      | hunting for the 0xA5 header
// P_CMD      | expecting the command code
// P_D3..P_D0 | collecting the big-endian payload
// P_SUM      | checksum byte; command decoded and applied
module lidar_cmd_rx #(
    parameter int BAUD_DIV    = 434,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rs232_rx,
    output logic [25:0] time_set,
    output logic [8:0]  resolution,
    output logic        enable,
    output logic        serialsend_flag,
    output logic        cmd_strobe,
    output logic [7:0]  cmd_code,
    output logic        cmd_err
);
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_HDR, P_CMD, P_D3, P_D2, P_D1, P_D0, P_SUM} p_state_t;

    rx_state_t     rx_state, rx_nx;
    p_state_t      p_state, p_nx;
    logic          rx_meta, rx_sync, rx_prev;
    logic          rx_fall, baud_tick;
    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    rx_byte;
    logic          byte_vld, frame_err;
    logic [7:0]    cmd_reg;
    logic [31:0]   payload;
    logic [7:0]    sum;
    logic          apply_time, apply_res, apply_en, reject;
    logic          apply_any;
    logic          timeout;

    // Sync flops reset low so a line held low through reset never looks like a start edge.
    assign rx_fall   = rx_prev && !rx_sync;
    assign baud_tick = (baud_cnt == '0);
    assign apply_any = apply_time || apply_res || apply_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            p_state  <= P_HDR;
        end else begin
            rx_state <= rx_nx;
            p_state  <= p_nx;
        end
    end

    always_comb begin
        rx_nx = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_nx = RX_START;
            RX_START: if (baud_tick) rx_nx = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (baud_tick && bit_cnt == 4'd7) rx_nx = RX_STOP;
            RX_STOP:  if (baud_tick) rx_nx = RX_IDLE;
            default:  rx_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta   <= 1'b0;
            rx_sync   <= 1'b0;
            rx_prev   <= 1'b0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            rx_byte   <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rs232_rx;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            if (rx_state == RX_IDLE) begin
                baud_cnt <= HALF_LAST;
                bit_cnt  <= '0;
            end else if (baud_tick) begin
                baud_cnt <= BAUD_LAST;
            end else begin
                baud_cnt <= baud_cnt - 1'b1;
            end
            if (rx_state == RX_DATA && baud_tick) begin
                rx_byte <= {rx_sync, rx_byte[7:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (rx_state == RX_STOP && baud_tick) begin
                byte_vld  <= rx_sync;
                frame_err <= !rx_sync;
            end
        end
    end

    always_comb begin
        p_nx       = p_state;
        apply_time = 1'b0;
        apply_res  = 1'b0;
        apply_en   = 1'b0;
        reject     = 1'b0;
        if (frame_err || timeout) begin
            p_nx = P_HDR;
        end else if (byte_vld) begin
            case (p_state)
                P_HDR: if (rx_byte == 8'hA5) p_nx = P_CMD;
                P_CMD: p_nx = P_D3;
                P_D3:  p_nx = P_D2;
                P_D2:  p_nx = P_D1;
                P_D1:  p_nx = P_D0;
                P_D0:  p_nx = P_SUM;
                P_SUM: begin
                    p_nx = P_HDR;
                    if (rx_byte != sum) begin
                        reject = 1'b1;
                    end else begin
                        case (cmd_reg)
                            8'h01: begin
                                if (payload[31:26] == 6'd0) apply_time = 1'b1;
                                else                        reject     = 1'b1;
                            end
                            8'h02: begin
                                if (payload == 32'd0 || payload > 32'd360) reject    = 1'b1;
                                else                                       apply_res = 1'b1;
                            end
                            8'h03:   apply_en = 1'b1;
                            default: reject   = 1'b1;
                        endcase
                    end
                end
                default: p_nx = P_HDR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_reg <= '0;
            payload <= '0;
            sum     <= '0;
        end else if (byte_vld) begin
            case (p_state)
                P_CMD: begin
                    cmd_reg <= rx_byte;
                    sum     <= rx_byte;
                end
                P_D3, P_D2, P_D1, P_D0: begin
                    payload <= {payload[23:0], rx_byte};
                    sum     <= sum + rx_byte;
                end
                default: ;
            endcase
        end
    end

`ifdef CMD_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_run;

    // Only counts idle gaps inside a frame; any received byte reloads it.
    assign tmo_run = (p_state != P_HDR) && (rx_state == RX_IDLE) && !byte_vld;
    assign timeout = tmo_run && (tmo_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n || !tmo_run) tmo_cnt <= TW'(TIMEOUT_CYC - 1);
        else if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            time_set        <= 26'd22000;
            resolution      <= 9'd10;
            enable          <= 1'b1;
            serialsend_flag <= 1'b1;
            cmd_strobe      <= 1'b0;
            cmd_code        <= 8'h00;
            cmd_err         <= 1'b0;
        end else begin
            cmd_strobe <= apply_any;
            cmd_err    <= reject || frame_err || timeout;
            if (apply_time) time_set <= payload[25:0];
            if (apply_res)  resolution <= payload[8:0];
            if (apply_en) begin
                enable          <= payload[0];
                serialsend_flag <= payload[1];
            end
            if (apply_any) cmd_code <= cmd_reg;
        end
    end

endmodule

// File: tb/tb_lidar_cmd_rx.sv
// Scoreboard bench for lidar_cmd_rx: expected command outcomes are queued as frames are sent
// and checked against each cmd_strobe / cmd_err pulse.
module tb_lidar_cmd_rx;
    localparam int BAUD = 16;
    localparam int TMO  = 2000;
    localparam int LAT  = 12;   // stop bit driven -> outputs visible, in clocks

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rs232_rx = 1'b1;
    logic [25:0] time_set;
    logic [8:0]  resolution;
    logic        enable;
    logic        serialsend_flag;
    logic        cmd_strobe;
    logic [7:0]  cmd_code;
    logic        cmd_err;

    lidar_cmd_rx #(.BAUD_DIV(BAUD), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rs232_rx(rs232_rx),
        .time_set(time_set),
        .resolution(resolution),
        .enable(enable),
        .serialsend_flag(serialsend_flag),
        .cmd_strobe(cmd_strobe),
        .cmd_code(cmd_code),
        .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          err;
        bit          chk_lat;
        logic [7:0]  code;
        logic [25:0] ts;
        logic [8:0]  res;
        bit          en;
        bit          ssf;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   last_stop_cyc = 0;

    logic [25:0] m_ts;
    logic [8:0]  m_res;
    bit          m_en, m_ssf;
    logic [7:0]  m_code;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ts = 26'd22000; m_res = 9'd10; m_en = 1'b1; m_ssf = 1'b1; m_code = 8'h00;
    endtask

    task automatic push_exp(input bit err, input bit chk_lat);
        exp_t e;
        e.err = err; e.chk_lat = chk_lat; e.code = m_code;
        e.ts = m_ts; e.res = m_res; e.en = m_en; e.ssf = m_ssf;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        rs232_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        rs232_rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rs232_rx = b[i];
            repeat (BAUD) @(negedge clk);
        end
        rs232_rx = stop;
        last_stop_cyc = cyc;
        repeat (BAUD) @(negedge clk);
        rs232_rx = 1'b1;
    endtask

    // sum_adj != 0 corrupts the checksum byte.
    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] pl, input logic [7:0] sum_adj);
        logic [7:0] s;
        bit ok;
        s  = cmd + pl[31:24] + pl[23:16] + pl[15:8] + pl[7:0];
        ok = (sum_adj == 8'd0);
        if (ok) begin
            case (cmd)
                8'h01: begin ok = (pl[31:26] == 6'd0); if (ok) m_ts = pl[25:0]; end
                8'h02: begin ok = (pl >= 32'd1 && pl <= 32'd360); if (ok) m_res = pl[8:0]; end
                8'h03: begin m_en = pl[0]; m_ssf = pl[1]; end
                default: ok = 1'b0;
            endcase
        end
        if (ok) m_code = cmd;
        push_exp(!ok, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(cmd, 1'b1);
        send_byte(pl[31:24], 1'b1);
        send_byte(pl[23:16], 1'b1);
        send_byte(pl[15:8], 1'b1);
        send_byte(pl[7:0], 1'b1);
        send_byte(s + sum_adj, 1'b1);
    endtask

    task automatic check_defaults(input string tag);
        check_eq({tag, "_time_set"}, 32'(time_set), 32'd22000);
        check_eq({tag, "_resolution"}, 32'(resolution), 32'd10);
        check_eq({tag, "_enable"}, 32'(enable), 32'd1);
        check_eq({tag, "_serialsend"}, 32'(serialsend_flag), 32'd1);
        check_eq({tag, "_strobe"}, 32'(cmd_strobe), 32'd0);
        check_eq({tag, "_code"}, 32'(cmd_code), 32'd0);
        check_eq({tag, "_err"}, 32'(cmd_err), 32'd0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && (cmd_strobe || cmd_err)) begin
            check_eq("pulse_exclusive", 32'(cmd_strobe & cmd_err), 32'd0);
            check_eq("evt_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("evt_err", 32'(cmd_err), 32'(e.err));
                check_eq("evt_strobe", 32'(cmd_strobe), 32'(!e.err));
                if (e.chk_lat) check_eq("evt_latency", 32'(cyc - last_stop_cyc), 32'(LAT));
                check_eq("evt_time_set", 32'(time_set), 32'(e.ts));
                check_eq("evt_resolution", 32'(resolution), 32'(e.res));
                check_eq("evt_enable", 32'(enable), 32'(e.en));
                check_eq("evt_serialsend", 32'(serialsend_flag), 32'(e.ssf));
                check_eq("evt_code", 32'(cmd_code), 32'(e.code));
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst_n = 1'b0;
        rs232_rx = 1'b1;
        repeat (4) @(negedge clk);
        check_defaults("rst");
        rst_n = 1'b1;
        idle(40);

        // short low glitch must be rejected silently
        rs232_rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(3 * BAUD);

        send_frame(8'h01, 32'd10000, 8'd0);
        idle(20);
        check_eq("ts_10000", 32'(time_set), 32'd10000);

        send_frame(8'h02, 32'd360, 8'd0);
        send_frame(8'h02, 32'd361, 8'd0);
        idle(20);
        check_eq("res_360_kept", 32'(resolution), 32'd360);
        send_frame(8'h02, 32'd0, 8'd0);
        send_frame(8'h02, 32'd1, 8'd0);
        idle(20);
        check_eq("res_1", 32'(resolution), 32'd1);

        send_frame(8'h03, 32'd0, 8'd0);
        send_frame(8'h03, 32'd0, 8'd1);
        idle(20);
        check_eq("en_0", 32'(enable), 32'd0);
        check_eq("ssf_0", 32'(serialsend_flag), 32'd0);

        send_frame(8'h01, 32'h0400_0000, 8'd0);
        send_frame(8'h01, 32'h03FF_FFFF, 8'd0);
        send_frame(8'h07, 32'd0, 8'd0);
        idle(20);
        check_eq("ts_max", 32'(time_set), 32'h03FF_FFFF);

        // garbage, then valid frame, then back-to-back byte with a bad stop bit
        send_byte(8'h55, 1'b1);
        send_byte(8'h00, 1'b1);
        send_frame(8'h03, 32'd3, 8'd0);
        push_exp(1'b1, 1'b1);
        send_byte(8'hA5, 1'b0);
        idle(40);
        check_eq("en_1", 32'(enable), 32'd1);
        check_eq("ssf_1", 32'(serialsend_flag), 32'd1);

        // reset mid-frame and mid-byte with the line held low across the release
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        rs232_rx = 1'b0;
        repeat (3 * BAUD) @(negedge clk);
        check_eq("q_pre_rst", 32'(sb_q.size()), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check_defaults("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2 * BAUD) @(negedge clk);
        idle(3 * BAUD);
        send_frame(8'h02, 32'd45, 8'd0);
        idle(20);
        check_eq("post_rst_ts", 32'(time_set), 32'd22000);
        check_eq("post_rst_res", 32'(resolution), 32'd45);

`ifdef CMD_RX_TIMEOUT_EN
        push_exp(1'b1, 1'b0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        idle(TMO + 4 * BAUD);
        check_eq("tmo_evt_seen", 32'(sb_q.size()), 32'd0);
        send_frame(8'h01, 32'd12345, 8'd0);
        idle(20);
        check_eq("tmo_next_ts", 32'(time_set), 32'd12345);
`endif

        idle(40);
        check_eq("q_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
